// File: rtl/atomic_reader_pkg.sv
// atomic_reader_pkg: shared state encoding and widths for the atomic counter reader
package atomic_reader_pkg;
   typedef enum logic [2:0] {IDLE, REQ_LO, REQ_HI, CAP_HI, VALID} state_t;
   localparam int RETRY_W = 4;
   localparam int SNAP_W  = 64;
endpackage

// File: rtl/reader_period_timer.sv
// reader_period_timer: counts idle cycles and pulses expire on the AUTO_PERIOD-th one (never when AUTO_PERIOD is 0)
module reader_period_timer #(
   parameter int AUTO_PERIOD = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);
   localparam int W = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (enable) cnt_q <= cnt_q + 1'b1;
   assign expire = AUTO_PERIOD != 0 && enable && cnt_q == W'(AUTO_PERIOD - 1);
endmodule

// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader: coherent 64-bit snapshot of the atomic counter via lo(atomic)/hi reads; ATOMIC_READER_DELTA_EN adds delta_o
module atomic_counter_reader
   import atomic_reader_pkg::*;
#(
   parameter int AUTO_PERIOD = 0,
   parameter int MAX_RETRY   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   output logic              req_o,
   output logic              atomic_o,
   input  logic              ack_i,
   input  logic [31:0]       count_i,
   output logic              snap_valid_o,
   input  logic              snap_ready_i,
   output logic [SNAP_W-1:0] snap_o,
   output logic              busy_o,
   output logic              err_o
`ifdef ATOMIC_READER_DELTA_EN
   ,
   output logic [SNAP_W-1:0] delta_o
`endif
);
   state_t               state_q, state_d;
   logic [RETRY_W-1:0]   retry_q;
   logic [31:0]          lo_q;
   logic [SNAP_W-1:0]    snap_q;
   logic                 err_q, fail, expire, launch;
   reader_period_timer #(.AUTO_PERIOD(AUTO_PERIOD)) u_timer (
      .clk   (clk),
      .reset (reset),
      .enable(state_q == IDLE),
      .clear (launch),
      .expire(expire)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      fail    = 1'b0;
      case (state_q)
         IDLE:    state_d = start_i || expire ? REQ_LO : IDLE;
         REQ_LO:  state_d = REQ_HI;
         REQ_HI:  begin state_d = CAP_HI; fail = !ack_i; end
         CAP_HI:  begin state_d = VALID; fail = !ack_i; end
         VALID:   state_d = snap_ready_i ? IDLE : VALID;
         default: state_d = IDLE;
      endcase
      if (fail) state_d = retry_q < RETRY_W'(MAX_RETRY) ? REQ_LO : IDLE;
   end
   assign launch = state_q == IDLE && state_d == REQ_LO;
   // Snapshot register loads only on entry to VALID so a retry never disturbs what is presented
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         retry_q <= '0;
         lo_q    <= '0;
         snap_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q   <= fail && state_d == IDLE;
         retry_q <= state_d == IDLE ? '0 : fail ? retry_q + 1'b1 : retry_q;
         if (state_q == REQ_HI && ack_i) lo_q <= count_i;
         if (state_q == CAP_HI && ack_i) snap_q <= {count_i, lo_q};
      end
   assign req_o        = state_q == REQ_LO || state_q == REQ_HI;
   assign atomic_o     = state_q == REQ_LO;
   assign busy_o       = state_q != IDLE;
   assign snap_valid_o = state_q == VALID;
   assign snap_o       = snap_q;
   assign err_o        = err_q;
`ifdef ATOMIC_READER_DELTA_EN
   logic [SNAP_W-1:0] prev_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) prev_q <= '0;
      else if (snap_valid_o && snap_ready_i) prev_q <= snap_q;
   assign delta_o = snap_q - prev_q;
`endif
endmodule

// File: tb/tb_atomic_counter_reader.sv
// tb_atomic_counter_reader: directed checks of the atomic reader against a shadowing counter model
module tb_atomic_counter_reader;
   logic        clk = 1'b0;
   logic        reset, start_i, snap_ready_i;
   logic        req_o, atomic_o, ack_i, snap_valid_o, busy_o, err_o;
   logic [31:0] count_i;
   logic [63:0] snap_o;
   logic        req2, atm2, valid2, busy2, err2;
   logic [63:0] snap2;
   logic        pend2 = 1'b0;
`ifdef ATOMIC_READER_DELTA_EN
   logic [63:0] delta_o, delta2;
`endif
   always #5 clk = ~clk;

   atomic_counter_reader dut (
      .clk(clk), .reset(reset), .start_i(start_i), .req_o(req_o), .atomic_o(atomic_o),
      .ack_i(ack_i), .count_i(count_i), .snap_valid_o(snap_valid_o), .snap_ready_i(snap_ready_i),
      .snap_o(snap_o), .busy_o(busy_o), .err_o(err_o)
`ifdef ATOMIC_READER_DELTA_EN
      , .delta_o(delta_o)
`endif
   );

   atomic_counter_reader #(.AUTO_PERIOD(8), .MAX_RETRY(3)) dut2 (
      .clk(clk), .reset(reset), .start_i(1'b0), .req_o(req2), .atomic_o(atm2),
      .ack_i(pend2), .count_i(32'hA5), .snap_valid_o(valid2), .snap_ready_i(1'b1),
      .snap_o(snap2), .busy_o(busy2), .err_o(err2)
`ifdef ATOMIC_READER_DELTA_EN
      , .delta_o(delta2)
`endif
   );

   // Counter model: an atomic low-word read freezes the full value for the following high-word read
   logic        load = 1'b0, trig = 1'b0, pend = 1'b0, pend_atm = 1'b0;
   logic [63:0] load_val = '0, ctr = '0, shadow = '0;
   int unsigned natomic = 0, err_cnt = 0, drop_until = 0, cyc = 0, t_last = 0, t_prev = 0, n2 = 0;
   always @(posedge clk) begin
      pend     <= req_o;
      pend_atm <= atomic_o;
      pend2    <= req2;
      cyc      <= cyc + 1;
      if (req_o && atomic_o) begin
         shadow  <= ctr;
         natomic <= natomic + 1;
      end
      if (err_o) err_cnt <= err_cnt + 1;
      if (load) ctr <= load_val;
      else if (trig) ctr <= ctr + 1;
      if (req2 && atm2) begin
         t_prev <= t_last;
         t_last <= cyc;
         n2     <= n2 + 1;
      end
   end
   assign ack_i   = pend && natomic > drop_until;
   assign count_i = pend_atm ? shadow[31:0] : shadow[63:32];

   int total = 0, bad = 0;
   logic [63:0] prev_model = '0;

   task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask
   task automatic chk_snap(input string tag, input logic [63:0] exp);
      chk64(tag, snap_o, exp);
`ifdef ATOMIC_READER_DELTA_EN
      chk64({tag, "_delta"}, delta_o, exp - prev_model);
`endif
   endtask
   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!snap_valid_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk1(tag, snap_valid_o, 1'b1);
   endtask
   task automatic preload(input logic [63:0] v);
      load = 1'b1; load_val = v;
      @(negedge clk);
      load = 1'b0;
   endtask
   task automatic kick;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask
   task automatic accept(input logic [63:0] v);
      snap_ready_i = 1'b1;
      @(negedge clk);
      snap_ready_i = 1'b0;
      prev_model = v;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int unsigned base, e0;
      reset = 1'b1; start_i = 1'b0; snap_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_req", req_o, 1'b0);
      chk1("rst_atomic", atomic_o, 1'b0);
      chk1("rst_valid", snap_valid_o, 1'b0);
      chk64("rst_snap", snap_o, 64'h0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Cycle-exact latency from a start pulse
      preload(64'h0000_0001_0000_0005);
      kick;
      chk1("c1_req", req_o, 1'b1);
      chk1("c1_atomic", atomic_o, 1'b1);
      @(negedge clk);
      chk1("c2_req", req_o, 1'b1);
      chk1("c2_atomic", atomic_o, 1'b0);
      @(negedge clk);
      chk1("c3_req", req_o, 1'b0);
      chk1("c3_valid", snap_valid_o, 1'b0);
      chk1("c3_busy", busy_o, 1'b1);
      @(negedge clk);
      chk1("c4_valid", snap_valid_o, 1'b1);
      chk_snap("c4_snap", 64'h0000_0001_0000_0005);

      // Backpressure: output holds, start pulses ignored, no queued start after accept
      for (int i = 0; i < 10; i++) begin
         start_i = i[0];
         @(negedge clk);
         chk1("hold_valid", snap_valid_o, 1'b1);
         chk64("hold_snap", snap_o, 64'h0000_0001_0000_0005);
      end
      snap_ready_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      snap_ready_i = 1'b0; start_i = 1'b0;
      prev_model = 64'h0000_0001_0000_0005;
      chk1("acc_valid", snap_valid_o, 1'b0);
      chk1("acc_busy", busy_o, 1'b0);
      @(negedge clk);
      chk1("noqueue_busy", busy_o, 1'b0);
      chk1("noqueue_req", req_o, 1'b0);

      // Counter incrementing across the 32-bit boundary during the read
      preload(64'h0000_0000_FFFF_FFFF);
      trig = 1'b1;
      kick;
      wait_valid("torn_wait");
      trig = 1'b0;
      chk_snap("torn_snap", 64'h0000_0001_0000_0000);
      accept(64'h0000_0001_0000_0000);

      // Two dropped sequences, third succeeds
      preload(64'h0000_0002_0000_0007);
      base = natomic; e0 = err_cnt;
      drop_until = natomic + 2;
      kick;
      wait_valid("retry_wait");
      chk64("retry_attempts", 64'(natomic - base), 64'd3);
      chk64("retry_noerr", 64'(err_cnt - e0), 64'd0);
      chk_snap("retry_snap", 64'h0000_0002_0000_0007);
      accept(64'h0000_0002_0000_0007);
      drop_until = 0;

      // Ack stuck low: MAX_RETRY+1 attempts then a single error pulse
      preload(64'h0000_0009_0000_0009);
      base = natomic; e0 = err_cnt;
      drop_until = 32'hFFFF_FFFF;
      kick;
      n = 0;
      while (!err_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk1("stuck_err", err_o, 1'b1);
      chk1("stuck_busy", busy_o, 1'b0);
      chk1("stuck_valid", snap_valid_o, 1'b0);
      chk64("stuck_snap", snap_o, 64'h0000_0002_0000_0007);
      @(negedge clk);
      chk1("stuck_err_drop", err_o, 1'b0);
      chk64("stuck_attempts", 64'(natomic - base), 64'd4);
      chk64("stuck_errcnt", 64'(err_cnt - e0), 64'd1);
      drop_until = 0;

      // Recovery after an error needs only one attempt
      base = natomic;
      kick;
      wait_valid("recov_wait");
      chk64("recov_attempts", 64'(natomic - base), 64'd1);
      chk_snap("recov_snap", 64'h0000_0009_0000_0009);
      accept(64'h0000_0009_0000_0009);

      // Reset in the middle of a sequence
      kick;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk1("mid_req", req_o, 1'b0);
      chk1("mid_atomic", atomic_o, 1'b0);
      chk1("mid_busy", busy_o, 1'b0);
      chk1("mid_valid", snap_valid_o, 1'b0);
      chk64("mid_snap", snap_o, 64'h0);
      chk1("mid_err", err_o, 1'b0);
      prev_model = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk1("post_rst_valid", snap_valid_o, 1'b0);
      chk1("post_rst_busy", busy_o, 1'b0);

      // Fresh snapshots after reset; second one differs by 25
      preload(64'h0000_0005_0000_0000);
      kick;
      wait_valid("fresh1_wait");
      chk_snap("fresh1_snap", 64'h0000_0005_0000_0000);
      accept(64'h0000_0005_0000_0000);
      preload(64'h0000_0005_0000_0019);
      kick;
      wait_valid("fresh2_wait");
      chk_snap("fresh2_snap", 64'h0000_0005_0000_0019);
      accept(64'h0000_0005_0000_0019);

      // Auto mode instance: period 8 idle cycles plus 4-cycle sequence
      repeat (40) @(negedge clk);
      chk1("auto_started", n2 >= 3, 1'b1);
      chk64("auto_interval", 64'(t_last - t_prev), 64'd12);
      chk64("auto_snap", snap2, 64'h0000_00A5_0000_00A5);
      chk1("auto_noerr", err2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
